// File: rtl/core_fetch_buffer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | core_fetch_buffer - prefetching fetch stage with in-order instr FIFO.    |
// | Optional macro FETCH_BYPASS_EN: zero-latency response path to the core. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module core_fetch_buffer #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] addr_mem_prog_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] val_mem_prog_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  input  logic                  instr_ready_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic                  run_q;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         outst_q, outst_d;
  logic [CW-1:0]         discard_q, discard_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         pq_rd_q, pq_rd_d, pq_wr_q, pq_wr_d;
  logic [DATA_WIDTH-1:0] fifo_instr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_q    [DEPTH];
  logic [ADDR_WIDTH-1:0] pcq_q        [DEPTH];

  logic accept, rsp, drop, bypass, push, pop, fifo_valid;
  logic unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc_i[1:0];

  // Credit covers both buffered and in-flight words, so a response always has a slot.
  assign mem_req_o       = run_q & (({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_C);
  assign addr_mem_prog_o = fetch_pc_q;
  assign accept          = mem_req_o & mem_gnt_i;
  assign rsp             = mem_rvalid_i & (outst_q != '0);
  assign drop            = rsp & (discard_q != '0);
  assign fifo_valid      = (count_q != '0);

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp & ~drop & ~fifo_valid;
`else
  assign bypass = 1'b0;
`endif

  assign instr_valid_o = fifo_valid | bypass;
  assign instr_o = fifo_valid ? fifo_instr_q[rd_ptr_q] : (bypass ? val_mem_prog_i : '0);
  assign pc_o    = fifo_valid ? fifo_pc_q[rd_ptr_q]    : (bypass ? pcq_q[pq_rd_q] : '0);

  assign push = rsp & ~drop & ~redirect_i & ~(bypass & instr_ready_i);
  assign pop  = fifo_valid & instr_ready_i & ~redirect_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    pq_rd_d    = pq_rd_q;
    pq_wr_d    = pq_wr_q;

    if (accept) begin
      fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
      pq_wr_d    = pq_wr_q + PW'(1);
    end
    if (rsp) pq_rd_d = pq_rd_q + PW'(1);

    case ({accept, rsp})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    discard_d = drop ? discard_q - CW'(1) : discard_q;

    // Everything still unanswered after this cycle belongs to the old stream.
    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
      discard_d  = outst_d;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      fetch_pc_q <= ADDR_WIDTH'(RESET_PC);
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      pq_rd_q    <= '0;
      pq_wr_q    <= '0;
    end else begin
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      pq_rd_q    <= pq_rd_d;
      pq_wr_q    <= pq_wr_d;
    end
  end

  // Storage arrays carry no reset; outputs are gated by the valid count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= val_mem_prog_i;
      fifo_pc_q[wr_ptr_q]    <= pcq_q[pq_rd_q];
    end
    if (accept) pcq_q[pq_wr_q] <= fetch_pc_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_core_fetch_buffer.sv
`default_nettype none
// Testbench for core_fetch_buffer: directed scenarios plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_core_fetch_buffer;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam logic [AW-1:0] RPC = '0;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          mem_gnt, mem_rvalid, ready, redirect;
  logic [DW-1:0] rdata;
  logic [AW-1:0] redirect_pc;
  logic          mem_req_o, instr_valid_o;
  logic [AW-1:0] addr_mem_prog_o, pc_o;
  logic [DW-1:0] instr_o;

  core_fetch_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_o(mem_req_o), .addr_mem_prog_o(addr_mem_prog_o),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .val_mem_prog_i(rdata),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_o(pc_o),
    .instr_ready_i(ready), .redirect_i(redirect), .redirect_pc_i(redirect_pc)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: next fetch address, unanswered request addresses,
  // number of those to be thrown away, and delivered-but-unconsumed words.
  logic [AW-1:0]    m_fpc;
  logic [AW-1:0]    m_outq[$];
  logic [AW+DW-1:0] m_fq[$];
  int               m_disc;
  bit               m_run;

  bit            e_req, e_valid, e_byp;
  logic [AW-1:0] e_addr, e_pc;
  logic [DW-1:0] e_instr;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {6'h2B, a, 6'h15, a};
  endfunction

  function void m_reset();
    m_fpc = RPC; m_outq.delete(); m_fq.delete(); m_disc = 0; m_run = 0;
  endfunction

  function void predict();
    e_req  = m_run && (m_fq.size() + m_outq.size() < DEPTH);
    e_addr = m_fpc;
    e_byp  = BYP && m_fq.size() == 0 && m_disc == 0 && mem_rvalid && m_outq.size() > 0;
    if (m_fq.size() > 0) begin
      e_valid = 1; e_instr = m_fq[0][AW+DW-1:AW]; e_pc = m_fq[0][AW-1:0];
    end else if (e_byp) begin
      e_valid = 1; e_instr = rdata; e_pc = m_outq[0];
    end else begin
      e_valid = 0; e_instr = '0; e_pc = '0;
    end
  endfunction

  function void model_step();
    bit acc, rsp;
    logic [AW-1:0] p;
    acc = e_req && mem_gnt;
    rsp = mem_rvalid && m_outq.size() > 0;
    if (!redirect && ready && m_fq.size() > 0) void'(m_fq.pop_front());
    if (rsp) begin
      p = m_outq.pop_front();
      if (m_disc > 0) m_disc--;
      else if (!redirect && !(e_byp && ready)) m_fq.push_back({rdata, p});
    end
    if (acc) begin
      m_outq.push_back(m_fpc);
      m_fpc = m_fpc + 10'd4;
    end
    if (redirect) begin
      m_fq.delete();
      m_fpc = {redirect_pc[AW-1:2], 2'b00};
      m_disc = m_outq.size();
    end
    m_run = 1;
  endfunction

  task automatic set_in(input bit g, input bit rv, input bit rdy, input bit rd, input logic [AW-1:0] rpc);
    mem_gnt = g; mem_rvalid = rv; ready = rdy; redirect = rd; redirect_pc = rpc;
    rdata = (rv && m_outq.size() > 0) ? mem_word(m_outq[0]) : DW'($urandom);
  endtask

  task automatic advance();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    set_in(0, 0, 0, 0, '0);
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    set_in(1, 1, 1, 0, '0);
    m_reset();
    for (int i = 0; i < 2; i++) begin
      #1;
      n_chk++;
      if ({mem_req_o, addr_mem_prog_o, instr_valid_o, instr_o, pc_o} !== {1'b0, RPC, 1'b0, 32'h0, 10'h0})
        $display("FAIL reset_state: req/addr/v/instr/pc got %b/%h/%b/%h/%h exp 0/%h/0/0/0",
                 mem_req_o, addr_mem_prog_o, instr_valid_o, instr_o, pc_o, RPC);
      else n_pass++;
      @(posedge clk);
    end
    #1 rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      set_in(1, 0, 1, 0, '0);
      predict(); @(negedge clk);
      n_chk++;
      if ({mem_req_o, addr_mem_prog_o} !== {e_req, e_addr})
        $display("FAIL reset_fetch c%0d: req/addr got %b/%h exp %b/%h", c, mem_req_o, addr_mem_prog_o, e_req, e_addr);
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_stream();
    logic [AW-1:0] seen[$];
    int nvalid = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      set_in(1, m_outq.size() > 0, 1, 0, '0);
      predict(); @(negedge clk);
      n_chk++;
      if ({mem_req_o, addr_mem_prog_o} !== {e_req, e_addr})
        $display("FAIL stream_fetch c%0d: req/addr got %b/%h exp %b/%h", c, mem_req_o, addr_mem_prog_o, e_req, e_addr);
      else n_pass++;
      n_chk++;
      if ({instr_valid_o, (instr_valid_o ? {instr_o, pc_o} : {(DW+AW){1'b0}})} !== {e_valid, e_instr, e_pc})
        $display("FAIL stream_issue c%0d: v/instr/pc got %b/%h/%h exp %b/%h/%h", c, instr_valid_o, instr_o, pc_o, e_valid, e_instr, e_pc);
      else n_pass++;
      if (instr_valid_o) seen.push_back(pc_o);
      if (c >= 3 && instr_valid_o) nvalid++;
      advance();
    end
    n_chk++;
    if ({seen[0], seen[1], seen[2]} !== {10'h000, 10'h004, 10'h008})
      $display("FAIL stream_pc_seq: got %h,%h,%h exp 000,004,008", seen[0], seen[1], seen[2]);
    else n_pass++;
    n_chk++;
    if (nvalid != 9) $display("FAIL stream_rate: valid cycles got %0d exp 9", nvalid);
    else n_pass++;
  endtask

  task automatic test_full();
    int acc = 0;
    bit resumed = 0;
    do_reset();
    for (int c = 0; c < 24; c++) begin
      set_in(1, m_outq.size() > 0, c >= 12, 0, '0);
      predict(); @(negedge clk);
      n_chk++;
      if ({mem_req_o, addr_mem_prog_o} !== {e_req, e_addr})
        $display("FAIL full_fetch c%0d: req/addr got %b/%h exp %b/%h", c, mem_req_o, addr_mem_prog_o, e_req, e_addr);
      else n_pass++;
      n_chk++;
      if ({instr_valid_o, (instr_valid_o ? {instr_o, pc_o} : {(DW+AW){1'b0}})} !== {e_valid, e_instr, e_pc})
        $display("FAIL full_issue c%0d: v/instr/pc got %b/%h/%h exp %b/%h/%h", c, instr_valid_o, instr_o, pc_o, e_valid, e_instr, e_pc);
      else n_pass++;
      if (c < 12 && mem_req_o && mem_gnt) acc++;
      if (c == 11) begin
        n_chk++;
        if (mem_req_o !== 1'b0) $display("FAIL full_noreq: mem_req_o got %b exp 0", mem_req_o);
        else n_pass++;
      end
      if (c >= 12 && mem_req_o) resumed = 1;
      advance();
    end
    n_chk++;
    if (acc != DEPTH) $display("FAIL full_accepts: got %0d exp %0d", acc, DEPTH);
    else n_pass++;
    n_chk++;
    if (!resumed) $display("FAIL full_resume: requests got none exp some");
    else n_pass++;
  endtask

  task automatic test_stall();
    int acc = 0;
    int stall = 0;
    bit st;
    do_reset();
    for (int c = 0; c < 30 && stall < 5; c++) begin
      st = (acc >= 4);
      set_in(!st, m_outq.size() > 0, 1, 0, '0);
      predict(); @(negedge clk);
      n_chk++;
      if ({instr_valid_o, (instr_valid_o ? {instr_o, pc_o} : {(DW+AW){1'b0}})} !== {e_valid, e_instr, e_pc})
        $display("FAIL stall_issue c%0d: v/instr/pc got %b/%h/%h exp %b/%h/%h", c, instr_valid_o, instr_o, pc_o, e_valid, e_instr, e_pc);
      else n_pass++;
      if (st) begin
        n_chk++;
        if ({mem_req_o, addr_mem_prog_o} !== {1'b1, 10'h010})
          $display("FAIL stall_hold c%0d: req/addr got %b/%h exp 1/010", c, mem_req_o, addr_mem_prog_o);
        else n_pass++;
        stall++;
      end else if (mem_req_o && mem_gnt) acc++;
      advance();
    end
    n_chk++;
    if (stall != 5) $display("FAIL stall_budget: stalled cycles got %0d exp 5", stall);
    else n_pass++;
  endtask

  task automatic test_redirect();
    int phase = 0;
    int tail = 0;
    bit got = 0;
    logic [AW-1:0] first_pc = '0;
    do_reset();
    for (int c = 0; c < 40 && tail < 12; c++) begin
      if (phase == 0 && m_fq.size() == 3 && m_outq.size() == 1) phase = 1;
      case (phase)
        0:       set_in(1, m_outq.size() > 0 && m_fq.size() < 3, 0, 0, '0);
        1:       set_in(1, 0, 1, 1, 10'h203);
        2:       set_in(0, 0, 1, 0, '0);
        default: set_in(1, m_outq.size() > 0, 1, 0, '0);
      endcase
      predict(); @(negedge clk);
      n_chk++;
      if ({mem_req_o, addr_mem_prog_o} !== {e_req, e_addr})
        $display("FAIL redir_fetch c%0d: req/addr got %b/%h exp %b/%h", c, mem_req_o, addr_mem_prog_o, e_req, e_addr);
      else n_pass++;
      n_chk++;
      if ({instr_valid_o, (instr_valid_o ? {instr_o, pc_o} : {(DW+AW){1'b0}})} !== {e_valid, e_instr, e_pc})
        $display("FAIL redir_issue c%0d: v/instr/pc got %b/%h/%h exp %b/%h/%h", c, instr_valid_o, instr_o, pc_o, e_valid, e_instr, e_pc);
      else n_pass++;
      if (phase == 2) begin
        n_chk++;
        if ({instr_valid_o, mem_req_o, addr_mem_prog_o} !== {1'b0, 1'b1, 10'h200})
          $display("FAIL redir_next: v/req/addr got %b/%b/%h exp 0/1/200", instr_valid_o, mem_req_o, addr_mem_prog_o);
        else n_pass++;
      end
      if (phase == 3) begin
        if (instr_valid_o && !got) begin got = 1; first_pc = pc_o; end
        tail++;
      end
      advance();
      if (phase == 1 || phase == 2) phase++;
    end
    n_chk++;
    if ({got, first_pc} !== {1'b1, 10'h200})
      $display("FAIL redir_first_pc: got valid=%b pc=%h exp 1/200", got, first_pc);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [AW-1:0] accq[$];
    logic [AW-1:0] delq[$];
    do_reset();
    for (int c = 0; c < 14; c++) begin
      if (c == 0) set_in(0, 0, 1, 1, 10'h3F8);
      else        set_in(1, m_outq.size() > 0, 1, 0, '0);
      predict(); @(negedge clk);
      n_chk++;
      if ({mem_req_o, addr_mem_prog_o} !== {e_req, e_addr})
        $display("FAIL wrap_fetch c%0d: req/addr got %b/%h exp %b/%h", c, mem_req_o, addr_mem_prog_o, e_req, e_addr);
      else n_pass++;
      n_chk++;
      if ({instr_valid_o, (instr_valid_o ? {instr_o, pc_o} : {(DW+AW){1'b0}})} !== {e_valid, e_instr, e_pc})
        $display("FAIL wrap_issue c%0d: v/instr/pc got %b/%h/%h exp %b/%h/%h", c, instr_valid_o, instr_o, pc_o, e_valid, e_instr, e_pc);
      else n_pass++;
      if (mem_req_o && mem_gnt) accq.push_back(addr_mem_prog_o);
      if (instr_valid_o) delq.push_back(pc_o);
      advance();
    end
    n_chk++;
    if ({accq[0], accq[1], accq[2]} !== {10'h3F8, 10'h3FC, 10'h000})
      $display("FAIL wrap_addr: got %h,%h,%h exp 3f8,3fc,000", accq[0], accq[1], accq[2]);
    else n_pass++;
    n_chk++;
    if ({delq[0], delq[1], delq[2]} !== {10'h3F8, 10'h3FC, 10'h000})
      $display("FAIL wrap_pc: got %h,%h,%h exp 3f8,3fc,000", delq[0], delq[1], delq[2]);
    else n_pass++;
  endtask

  task automatic test_bypass();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      set_in(c == 1, c == 2, 1, 0, '0);
      predict(); @(negedge clk);
      n_chk++;
      if ({instr_valid_o, (instr_valid_o ? {instr_o, pc_o} : {(DW+AW){1'b0}})} !== {e_valid, e_instr, e_pc})
        $display("FAIL byp_issue c%0d: v/instr/pc got %b/%h/%h exp %b/%h/%h", c, instr_valid_o, instr_o, pc_o, e_valid, e_instr, e_pc);
      else n_pass++;
      if (c >= 2) begin
        n_chk++;
        if (instr_valid_o !== ((c == 2) ? BYP : (c == 3) ? !BYP : 1'b0))
          $display("FAIL byp_latency c%0d: instr_valid_o got %b exp %b", c, instr_valid_o,
                   (c == 2) ? BYP : (c == 3) ? !BYP : 1'b0);
        else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      set_in($urandom_range(0, 1), m_outq.size() > 0, 0, 0, '0);
      predict(); advance();
    end
    #3 rst_n = 0;
    #1;
    n_chk++;
    if ({mem_req_o, addr_mem_prog_o, instr_valid_o, instr_o, pc_o} !== {1'b0, RPC, 1'b0, 32'h0, 10'h0})
      $display("FAIL async_reset: req/addr/v/instr/pc got %b/%h/%b/%h/%h exp 0/%h/0/0/0",
               mem_req_o, addr_mem_prog_o, instr_valid_o, instr_o, pc_o, RPC);
    else n_pass++;
    set_in(0, 0, 0, 0, '0);
    m_reset();
    @(posedge clk); #1 rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      set_in(1, m_outq.size() > 0, 1, 0, '0);
      predict(); @(negedge clk);
      n_chk++;
      if ({mem_req_o, addr_mem_prog_o, instr_valid_o, (instr_valid_o ? pc_o : 10'h0)} !== {e_req, e_addr, e_valid, e_pc})
        $display("FAIL async_restart c%0d: req/addr/v/pc got %b/%h/%b/%h exp %b/%h/%b/%h", c,
                 mem_req_o, addr_mem_prog_o, instr_valid_o, pc_o, e_req, e_addr, e_valid, e_pc);
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_random();
    bit rv;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (m_outq.size() > 0) rv = ($urandom_range(0, 9) < 6);
      else                   rv = ($urandom_range(0, 9) == 0);
      set_in($urandom_range(0, 9) < 6, rv, $urandom_range(0, 9) < 7,
             $urandom_range(0, 99) < 4, AW'($urandom));
      predict(); @(negedge clk);
      n_chk++;
      if ({mem_req_o, addr_mem_prog_o} !== {e_req, e_addr})
        $display("FAIL rand_fetch c%0d: req/addr got %b/%h exp %b/%h", c, mem_req_o, addr_mem_prog_o, e_req, e_addr);
      else n_pass++;
      n_chk++;
      if ({instr_valid_o, (instr_valid_o ? {instr_o, pc_o} : {(DW+AW){1'b0}})} !== {e_valid, e_instr, e_pc})
        $display("FAIL rand_issue c%0d: v/instr/pc got %b/%h/%h exp %b/%h/%h", c, instr_valid_o, instr_o, pc_o, e_valid, e_instr, e_pc);
      else n_pass++;
      advance();
    end
  endtask

  initial begin
    rst_n = 0;
    set_in(0, 0, 0, 0, '0);
    test_reset();
    test_stream();
    test_full();
    test_stall();
    test_redirect();
    test_wrap();
    test_bypass();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
